// File: rtl/tree_walker.sv
// Walks a configurable node tree one field token at a time, reporting the matched
// node, the resulting nesting level and an error code for every token.
module tree_walker #(
    parameter int ID_W         = 8,
    parameter int ADDR_W       = 8,
    parameter int NUM_NODES    = 16,
    parameter int MAX_CHILDREN = 4,
    parameter int MAX_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_we,
    input  logic [ADDR_W-1:0]                cfg_addr,
    input  logic [ID_W-1:0]                  cfg_id,
    input  logic [MAX_CHILDREN*ADDR_W-1:0]   cfg_children,
    input  logic                             walk_clr,
    input  logic                             tok_valid,
    output logic                             tok_ready,
    input  logic [ID_W-1:0]                  tok_id,
    input  logic [1:0]                       tok_kind,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ADDR_W-1:0]                out_node,
    output logic [$clog2(MAX_DEPTH+1)-1:0]   out_level,
    output logic [1:0]                       out_kind,
    output logic [1:0]                       out_err,
    output logic                             busy
);

    localparam int LVL_W  = $clog2(MAX_DEPTH + 1);
    localparam int IDX_W  = $clog2(NUM_NODES);
    localparam int SLOT_W = $clog2(MAX_CHILDREN);
    localparam int KCNT_W = $clog2(MAX_CHILDREN + 1);
    localparam int STK_W  = $clog2(MAX_DEPTH);

    localparam logic [1:0] KIND_LEAF  = 2'd0;
    localparam logic [1:0] KIND_OPEN  = 2'd1;
    localparam logic [1:0] KIND_CLOSE = 2'd2;
    localparam logic [1:0] KIND_BAD   = 2'd3;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_MISS  = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_UNDER = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        RESOLVE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ID_W-1:0]                node_id       [NUM_NODES];
    logic [MAX_CHILDREN*ADDR_W-1:0] node_children [NUM_NODES];
    logic [ADDR_W-1:0]              stack         [MAX_DEPTH];

    logic [ADDR_W-1:0] cur, cur_next;
    logic [LVL_W-1:0]  depth, depth_next;
    logic [KCNT_W-1:0] k, k_next;
    logic [ID_W-1:0]   tok_id_q;
    logic [1:0]        tok_kind_q;

    logic                       accept;
    logic                       push;
    logic                       capture;
    logic [ADDR_W-1:0]          res_node;
    logic [1:0]                 res_err;
    logic [MAX_CHILDREN*ADDR_W-1:0] cur_row;
    logic [ADDR_W-1:0]          child;
    logic                       child_hit;
    logic                       slot_miss;

    assign tok_ready = rst_n && (state == IDLE) && !walk_clr;
    assign accept    = tok_valid && tok_ready;
    assign out_valid = (state == EMIT);
    assign busy      = (state != IDLE);

    // Node table has no reset; writes are only honoured between tokens.
    always_ff @(posedge clk) begin
        if (cfg_we && state == IDLE && cfg_addr < ADDR_W'(NUM_NODES)) begin
            node_id[cfg_addr[IDX_W-1:0]]       <= cfg_id;
            node_children[cfg_addr[IDX_W-1:0]] <= cfg_children;
        end
    end

    assign cur_row   = node_children[cur[IDX_W-1:0]];
    assign child     = (k < KCNT_W'(MAX_CHILDREN)) ? cur_row[k[SLOT_W-1:0]*ADDR_W +: ADDR_W] : '0;
    assign slot_miss = (child == '0);
    assign child_hit = !slot_miss && (child < ADDR_W'(NUM_NODES)) &&
                       (node_id[child[IDX_W-1:0]] == tok_id_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        k_next     = k;
        depth_next = depth;
        cur_next   = cur;
        push       = 1'b0;
        capture    = 1'b0;
        res_node   = '0;
        res_err    = ERR_OK;
        case (state)
            IDLE: begin
                if (accept) begin
                    k_next     = '0;
                    state_next = (tok_kind == KIND_CLOSE || tok_kind == KIND_BAD) ? RESOLVE : SCAN;
                end else if (walk_clr) begin
                    depth_next = '0;
                    cur_next   = '0;
                end
            end
            SCAN: begin
                if (child_hit) begin
                    capture    = 1'b1;
                    res_node   = child;
                    state_next = EMIT;
                    if (tok_kind_q == KIND_OPEN) begin
                        if (depth == LVL_W'(MAX_DEPTH)) begin
                            res_err = ERR_OVER;
                        end else begin
                            push       = 1'b1;
                            depth_next = depth + LVL_W'(1);
                            cur_next   = child;
                        end
                    end
                end else if (slot_miss) begin
                    capture    = 1'b1;
                    res_err    = ERR_MISS;
                    state_next = EMIT;
                end else begin
                    k_next = k + KCNT_W'(1);
                end
            end
            RESOLVE: begin
                capture    = 1'b1;
                state_next = EMIT;
                if (tok_kind_q == KIND_BAD || depth == '0) begin
                    res_err = ERR_UNDER;
                end else begin
                    res_node   = cur;
                    depth_next = depth - LVL_W'(1);
                    cur_next   = stack[depth_next[STK_W-1:0]];
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Walk pointers, path stack and the result registers held through EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur        <= '0;
            depth      <= '0;
            k          <= '0;
            tok_id_q   <= '0;
            tok_kind_q <= '0;
            out_node   <= '0;
            out_level  <= '0;
            out_kind   <= '0;
            out_err    <= '0;
            for (int i = 0; i < MAX_DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            cur   <= cur_next;
            depth <= depth_next;
            k     <= k_next;
            if (accept) begin
                tok_id_q   <= tok_id;
                tok_kind_q <= tok_kind;
            end
            if (push) begin
                stack[depth[STK_W-1:0]] <= cur;
            end
            if (capture) begin
                out_node  <= res_node;
                out_level <= depth_next;
                out_kind  <= tok_kind_q;
                out_err   <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_tree_walker.sv
// Directed bench for tree_walker: a vector table for the basic walk plus hand-written
// sequences for overflow, output back-pressure, mid-scan reset, walk_clr and config range.
module tb_tree_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_id;
    logic [31:0] cfg_children;
    logic        walk_clr;
    logic        tok_valid;
    logic        tok_ready;
    logic [7:0]  tok_id;
    logic [1:0]  tok_kind;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_node;
    logic [2:0]  out_level;
    logic [1:0]  out_kind;
    logic [1:0]  out_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] id;
        logic [7:0] exp_node;
        logic [2:0] exp_level;
        logic [1:0] exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    tree_walker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_id       (cfg_id),
        .cfg_children (cfg_children),
        .walk_clr     (walk_clr),
        .tok_valid    (tok_valid),
        .tok_ready    (tok_ready),
        .tok_id       (tok_id),
        .tok_kind     (tok_kind),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_node     (out_node),
        .out_level    (out_level),
        .out_kind     (out_kind),
        .out_err      (out_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [7:0] addr, input logic [7:0] id, input logic [31:0] kids);
        cfg_we       = 1'b1;
        cfg_addr     = addr;
        cfg_id       = id;
        cfg_children = kids;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        @(negedge clk);
    endtask

    // Presents one token at a negedge, then waits (bounded) for out_valid.
    task automatic apply_stimulus(input logic [1:0] kind, input logic [7:0] id, output int lat);
        int  t_acc;
        bit  seen;
        tok_kind  = kind;
        tok_id    = id;
        tok_valid = 1'b1;
        check("tok_ready_idle", tok_ready, 1);
        t_acc = cyc;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        seen = 0;
        lat  = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                lat  = cyc - t_acc;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    task automatic check_output(input string tag, input vec_t v, input int lat);
        check({tag, "_node"},  out_node,  v.exp_node);
        check({tag, "_level"}, out_level, v.exp_level);
        check({tag, "_err"},   out_err,   v.exp_err);
        check({tag, "_kind"},  out_kind,  v.kind);
        check({tag, "_lat"},   lat,       v.exp_lat);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   lat;
        vec_t v;

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_id = '0; cfg_children = '0;
        walk_clr = 1'b0; tok_valid = 1'b0; tok_id = '0; tok_kind = '0; out_ready = 1'b1;

        vecs[0] = '{kind: 2'd0, id: 8'h0B, exp_node: 8'd2, exp_level: 3'd0, exp_err: 2'd0, exp_lat: 3};
        vecs[1] = '{kind: 2'd1, id: 8'h0A, exp_node: 8'd1, exp_level: 3'd1, exp_err: 2'd0, exp_lat: 2};
        vecs[2] = '{kind: 2'd0, id: 8'h05, exp_node: 8'd3, exp_level: 3'd1, exp_err: 2'd0, exp_lat: 2};
        vecs[3] = '{kind: 2'd2, id: 8'h00, exp_node: 8'd1, exp_level: 3'd0, exp_err: 2'd0, exp_lat: 2};
        vecs[4] = '{kind: 2'd0, id: 8'h07, exp_node: 8'd0, exp_level: 3'd0, exp_err: 2'd1, exp_lat: 4};
        vecs[5] = '{kind: 2'd0, id: 8'h0A, exp_node: 8'd1, exp_level: 3'd0, exp_err: 2'd0, exp_lat: 2};
        vecs[6] = '{kind: 2'd2, id: 8'h00, exp_node: 8'd0, exp_level: 3'd0, exp_err: 2'd3, exp_lat: 2};
        vecs[7] = '{kind: 2'd3, id: 8'h0B, exp_node: 8'd0, exp_level: 3'd0, exp_err: 2'd3, exp_lat: 2};

        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy",      busy,      0);
        check("rst_tok_ready", tok_ready, 0);
        check("rst_out_node",  out_node,  0);
        check("rst_out_level", out_level, 0);
        check("rst_out_err",   out_err,   0);
        check("rst_out_kind",  out_kind,  0);
        rst_n = 1'b1;
        @(negedge clk);

        cfg_write(8'd0, 8'h00, 32'h0000_0201);
        cfg_write(8'd1, 8'h0A, 32'h0000_0003);
        cfg_write(8'd2, 8'h0B, 32'h0000_0000);
        cfg_write(8'd3, 8'h05, 32'h0000_0000);

        $display("[TB] basic walk table");
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].kind, vecs[i].id, lat);
            check_output($sformatf("vec%0d", i), vecs[i], lat);
        end

        $display("[TB] depth overflow");
        cfg_write(8'd1, 8'h0A, 32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            v = '{kind: 2'd1, id: 8'h0A, exp_node: 8'd1,
                  exp_level: (i < 4) ? 3'(i + 1) : 3'd4,
                  exp_err: (i < 4) ? 2'd0 : 2'd2, exp_lat: 2};
            apply_stimulus(v.kind, v.id, lat);
            check_output($sformatf("open%0d", i), v, lat);
        end

        $display("[TB] output back-pressure");
        out_ready = 1'b0;
        apply_stimulus(2'd2, 8'h00, lat);
        check("hold_lat", lat, 2);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",     out_valid, 1);
            check("hold_node",      out_node,  1);
            check("hold_level",     out_level, 3);
            check("hold_err",       out_err,   0);
            check("hold_tok_ready", tok_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_released", out_valid, 0);

        $display("[TB] reset during scan");
        tok_kind = 2'd0; tok_id = 8'h99; tok_valid = 1'b1;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        @(negedge clk);
        check("scan_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_busy",      busy,      0);
        check("arst_out_valid", out_valid, 0);
        check("arst_tok_ready", tok_ready, 0);
        check("arst_out_level", out_level, 0);
        check("arst_out_err",   out_err,   0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_no_output", out_valid, 0);
        v = '{kind: 2'd0, id: 8'h0B, exp_node: 8'd2, exp_level: 3'd0, exp_err: 2'd0, exp_lat: 3};
        apply_stimulus(v.kind, v.id, lat);
        check_output("after_rst", v, lat);

        $display("[TB] out-of-range config write");
        cfg_write(8'd18, 8'h77, 32'h0000_0000);
        apply_stimulus(v.kind, v.id, lat);
        check_output("cfg_range", v, lat);

        $display("[TB] walk_clr");
        v = '{kind: 2'd1, id: 8'h0A, exp_node: 8'd1, exp_level: 3'd1, exp_err: 2'd0, exp_lat: 2};
        apply_stimulus(v.kind, v.id, lat);
        check_output("clr_open1", v, lat);
        v.exp_level = 3'd2;
        apply_stimulus(v.kind, v.id, lat);
        check_output("clr_open2", v, lat);
        walk_clr = 1'b1; tok_valid = 1'b1; tok_kind = 2'd0; tok_id = 8'h0B;
        #1;
        check("clr_tok_ready", tok_ready, 0);
        @(posedge clk);
        #1 begin walk_clr = 1'b0; tok_valid = 1'b0; end
        @(negedge clk);
        check("clr_not_accepted", busy, 0);
        v = '{kind: 2'd0, id: 8'h0B, exp_node: 8'd2, exp_level: 3'd0, exp_err: 2'd0, exp_lat: 3};
        apply_stimulus(v.kind, v.id, lat);
        check_output("after_clr", v, lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
